// File: rtl/sram_pkg.sv
// Shared phase encoding, width helper and strobe-exclusivity check for the SRAM array sequencer.
// Pure declarations: no latency, no flow control.
`ifndef SRAM_PKG_SV
`define SRAM_PKG_SV

`define SRAM_STROBE_EXCL(clk_s, rst_s, pre_s, wl_s, sa_s) \
    assert property (@(posedge clk_s) disable iff (!(rst_s)) $onehot0({(pre_s), |(wl_s), (sa_s)}))

package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        ACC   = 2'd2,
        SENSE = 2'd3
    } phase_t;

    // Never returns 0 so a single-word array still gets a 1-bit address.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`endif

// File: rtl/sram_wl_decoder.sv
// Address to one-hot wordline decoder with enable; out-of-range addresses raise no line and clear o_hit.
// Combinational, no flow control.
module sram_wl_decoder
    import sram_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = clog2(DEPTH)
)(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_en,
    output logic [DEPTH-1:0]  o_wl,
    output logic              o_hit
);

    always_comb begin
        o_wl  = '0;
        o_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_addr == ADDR_W'(i)) begin
                o_hit   = 1'b1;
                o_wl[i] = i_en;
            end
        end
    end

endmodule

// File: rtl/sram_6t_array.sv
// Behavioural 6T SRAM array with PRE -> ACC -> SENSE access sequencer; read data 4 cycles after accept, write busy 3 cycles.
// One request at a time: req_ready is high only in IDLE, so requests wait upstream while an access is in flight.
module sram_6t_array
    import sram_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int ADDR_W = clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              pre_en,
    output logic [DEPTH-1:0]  wl,
    output logic              wd_en,
    output logic              sa_en
);

    phase_t              r_state;
    phase_t              w_state_nxt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    w_wl;
    logic                w_hit;
    logic                w_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = PRE;
            PRE:     w_state_nxt = ACC;
            ACC:     w_state_nxt = r_we ? IDLE : SENSE;
            SENSE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        pre_en    = 1'b0;
        w_acc     = 1'b0;
        sa_en     = 1'b0;
        case (r_state)
            IDLE:    req_ready = 1'b1;
            PRE:     pre_en    = 1'b1;
            ACC:     w_acc     = 1'b1;
            SENSE:   sa_en     = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    sram_wl_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wl_decoder (
        .i_addr (r_addr),
        .i_en   (w_acc),
        .o_wl   (w_wl),
        .o_hit  (w_hit)
    );

    // Out-of-range addresses raise no wordline, so the write driver must stay off too.
    assign wl        = w_wl;
    assign wd_en     = w_acc & r_we & w_hit;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            r_rsp_valid <= (r_state == SENSE);
            if (r_state == SENSE) begin
                r_rdata <= w_hit ? r_mem[r_addr] : '0;
            end
        end
    end

    // Storage is deliberately not reset; a reset landing on the ACC edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (rst_n && wd_en) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    `SRAM_STROBE_EXCL(clk, rst_n, pre_en, wl, sa_en);

    assert property (@(posedge clk) disable iff (!rst_n) wd_en |-> (|wl));

endmodule

// File: tb/tb_sram_6t_array.sv
// Directed bench for sram_6t_array: a DEPTH=16 instance for the main flows and a DEPTH=12 instance for out-of-range addresses.
module tb_sram_6t_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_we = 1'b0;
    logic [3:0]  drv_addr = 4'd0;
    logic [7:0]  drv_wdata = 8'd0;

    logic        a_valid, a_ready, a_rsp_valid, a_pre, a_wd, a_sa;
    logic [7:0]  a_rdata;
    logic [15:0] a_wl;
    logic        b_valid, b_ready, b_rsp_valid, b_pre, b_wd, b_sa;
    logic [7:0]  b_rdata;
    logic [11:0] b_wl;

    logic        m_ready, m_rsp_valid, m_pre, m_wd, m_sa;
    logic [7:0]  m_rdata;
    logic [15:0] m_wl;

    int total = 0;
    int passes = 0;
    int fails = 0;
    int viol = 0;
    int wdv = 0;

    always #5 clk = ~clk;

    assign a_valid     = drv_valid & ~sel;
    assign b_valid     = drv_valid & sel;
    assign m_ready     = sel ? b_ready : a_ready;
    assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign m_pre       = sel ? b_pre : a_pre;
    assign m_wd        = sel ? b_wd : a_wd;
    assign m_sa        = sel ? b_sa : a_sa;
    assign m_rdata     = sel ? b_rdata : a_rdata;
    assign m_wl        = sel ? {4'b0000, b_wl} : a_wl;

    sram_6t_array #(.DATA_W(8), .DEPTH(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_we    (drv_we),
        .req_addr  (drv_addr),
        .req_wdata (drv_wdata),
        .rsp_valid (a_rsp_valid),
        .rsp_rdata (a_rdata),
        .pre_en    (a_pre),
        .wl        (a_wl),
        .wd_en     (a_wd),
        .sa_en     (a_sa)
    );

    sram_6t_array #(.DATA_W(8), .DEPTH(12)) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_we    (drv_we),
        .req_addr  (drv_addr),
        .req_wdata (drv_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_rdata (b_rdata),
        .pre_en    (b_pre),
        .wl        (b_wl),
        .wd_en     (b_wd),
        .sa_en     (b_sa)
    );

    always @(negedge clk) begin
        if (!$onehot0({a_pre, |a_wl, a_sa})) viol++;
        if (!$onehot0({b_pre, |b_wl, b_sa})) viol++;
        if (a_wd && (a_wl == 16'h0)) wdv++;
        if (b_wd && (b_wl == 12'h0)) wdv++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for req_ready, presents one request for one edge; returns at the negedge of the PRE cycle.
    task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d, output int waited);
        waited = 0;
        @(negedge clk);
        while (!m_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", {31'd0, m_ready}, 32'd1);
        drv_valid = 1'b1;
        drv_we    = we;
        drv_addr  = a;
        drv_wdata = d;
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [7:0] rd, output logic vld);
        int w;
        issue(1'b0, a, 8'h00, w);
        repeat (3) @(negedge clk);
        rd  = m_rdata;
        vld = m_rsp_valid;
    endtask

    initial begin
        int         w;
        int         wsum;
        int         lowpre;
        logic [7:0] rd;
        logic       vld;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rdata", {24'd0, a_rdata}, 32'd0);
        chk("rst_strobes", {16'd0, a_wl} | {29'd0, a_pre, a_wd, a_sa}, 32'd0);
        rst_n = 1'b1;

        // Write 0xA5 @3 then read it back with phase-by-phase strobe checks
        issue(1'b1, 4'd3, 8'hA5, w);
        chk("wr_pre", {31'd0, m_pre}, 32'd1);
        @(negedge clk);
        chk("wr_acc_wl", {16'd0, m_wl}, 32'h0008);
        chk("wr_acc_wd", {31'd0, m_wd}, 32'd1);
        @(negedge clk);
        chk("wr_done_ready", {31'd0, m_ready}, 32'd1);
        issue(1'b0, 4'd3, 8'h00, w);
        chk("rd_pre", {31'd0, m_pre}, 32'd1);
        chk("rd_pre_wl", {16'd0, m_wl}, 32'd0);
        @(negedge clk);
        chk("rd_acc_wl", {16'd0, m_wl}, 32'h0008);
        chk("rd_acc_wd", {31'd0, m_wd}, 32'd0);
        @(negedge clk);
        chk("rd_sense_sa", {31'd0, m_sa}, 32'd1);
        chk("rd_sense_wl", {16'd0, m_wl}, 32'd0);
        chk("rd_sense_vld", {31'd0, m_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_rsp_valid", {31'd0, m_rsp_valid}, 32'd1);
        chk("rd_rdata", {24'd0, m_rdata}, 32'h00A5);
        @(negedge clk);
        chk("rd_pulse_end", {31'd0, m_rsp_valid}, 32'd0);
        chk("rd_rdata_held", {24'd0, m_rdata}, 32'h00A5);

        // Back-to-back writes to every word, then read all
        wsum = 0;
        lowpre = 0;
        for (int a = 0; a < 16; a++) begin
            issue(1'b1, 4'(a), 8'(a) ^ 8'h5A, w);
            if (a > 0) wsum += w;
            if (!m_ready) lowpre++;
        end
        chk("b2b_wait_cycles", wsum, 32'd15);
        chk("b2b_ready_low_pre", lowpre, 32'd16);
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), rd, vld);
            chk("sweep_vld", {31'd0, vld}, 32'd1);
            chk("sweep_rdata", {24'd0, rd}, {24'd0, 8'(a) ^ 8'h5A});
        end

        // Request held while busy with a changed address: only the IDLE-cycle request is taken
        issue(1'b0, 4'd2, 8'h00, w);
        drv_valid = 1'b1;
        drv_we    = 1'b0;
        drv_addr  = 4'd9;
        @(negedge clk);
        chk("busy_acc_wl", {16'd0, m_wl}, 32'h0004);
        @(negedge clk);
        @(negedge clk);
        chk("busy_rsp_vld", {31'd0, m_rsp_valid}, 32'd1);
        chk("busy_rdata", {24'd0, m_rdata}, 32'h0058);
        chk("busy_ready", {31'd0, m_ready}, 32'd1);
        @(negedge clk);
        drv_valid = 1'b0;
        chk("busy2_pre", {31'd0, m_pre}, 32'd1);
        @(negedge clk);
        chk("busy2_acc_wl", {16'd0, m_wl}, 32'h0200);
        @(negedge clk);
        @(negedge clk);
        chk("busy2_rsp_vld", {31'd0, m_rsp_valid}, 32'd1);
        chk("busy2_rdata", {24'd0, m_rdata}, 32'h0053);

        // Reset landing on the ACC edge of a write must not commit it
        issue(1'b1, 4'd7, 8'h11, w);
        issue(1'b1, 4'd7, 8'h3C, w);
        @(negedge clk);
        chk("abort_acc_wl", {16'd0, m_wl}, 32'h0080);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, m_ready}, 32'd1);
        chk("abort_wl", {16'd0, m_wl}, 32'd0);
        rst_n = 1'b1;
        do_read(4'd7, rd, vld);
        chk("abort_rd_vld", {31'd0, vld}, 32'd1);
        chk("abort_rd_old", {24'd0, rd}, 32'h0011);
        // Reset during SENSE cancels the pending response
        issue(1'b0, 4'd3, 8'h00, w);
        repeat (2) @(negedge clk);
        chk("cancel_sense", {31'd0, m_sa}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("cancel_rsp_vld", {31'd0, m_rsp_valid}, 32'd0);
        chk("cancel_rdata", {24'd0, m_rdata}, 32'd0);
        rst_n = 1'b1;

        // DEPTH=12 instance: address 13 is out of range
        sel = 1'b1;
        issue(1'b1, 4'd1, 8'h77, w);
        issue(1'b1, 4'd13, 8'hFF, w);
        @(negedge clk);
        chk("oor_wr_wl", {16'd0, m_wl}, 32'd0);
        chk("oor_wr_wd", {31'd0, m_wd}, 32'd0);
        do_read(4'd1, rd, vld);
        chk("oor_pre_rdata", {24'd0, rd}, 32'h0077);
        issue(1'b0, 4'd13, 8'h00, w);
        @(negedge clk);
        chk("oor_rd_wl", {16'd0, m_wl}, 32'd0);
        repeat (2) @(negedge clk);
        chk("oor_rd_vld", {31'd0, m_rsp_valid}, 32'd1);
        chk("oor_rd_rdata", {24'd0, m_rdata}, 32'd0);
        do_read(4'd1, rd, vld);
        chk("oor_word1_kept", {24'd0, rd}, 32'h0077);
        sel = 1'b0;

        @(negedge clk);
        chk("strobe_exclusive", viol, 32'd0);
        chk("wd_without_wl", wdv, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
